seq101_stream_ctrl: RTL
=======================

// Module: seq101_stream_ctrl
// PURPOSE
//   Frame sequencer for the serial "101" Mealy detector. Accepts a parallel byte on a start
//   pulse, clears the detector, then streams the byte MSB-first into the detector's din, one
//   bit per clock. Counts the detector's match pulses, then reports the count with a done
//   pulse. Sits between the ui_in byte bus and the detector instance in the top level.
// PARAMETERS
//   DATA_W  8  frame width in bits, >=2; bits streamed per frame
//   CNT_W   4  match counter width; count saturates at 2**CNT_W-1
// PORTS
//   clk          in   1       system clock, all flops rising-edge
//   rst_n        in   1       asynchronous active-low reset
//   start_i      in   1       frame request; sampled only in IDLE (and DONE, see CONFIGURATION)
//   data_i       in   DATA_W  frame payload, captured on the accepted start_i edge
//   busy_o       out  1       high in CLEAR, SHIFT and DONE
//   done_o       out  1       one-cycle pulse in DONE; count_o valid
//   count_o      out  CNT_W   match count of the last frame; held until the next frame is accepted
//   det_clr_o    out  1       registered detector clear; top ANDs ~det_clr_o into detector rst_n
//   det_din_o    out  1       serial bit to detector din (= shift_reg[DATA_W-1])
//   det_vld_o    out  1       high while det_din_o carries a frame bit (SHIFT)
//   match_i      in   1       detector Mealy output z (combinational from det_din_o)
// BEHAVIOUR
//   - Reset: state=IDLE; shift_reg=0, bit_cnt=0, count_o=0; all outputs 0.
//   - FSM states: IDLE, CLEAR, SHIFT, DONE.
//   - IDLE: start_i=1 -> capture data_i into shift_reg, bit_cnt=0, count_o=0, go to CLEAR.
//     start_i=0 -> stay in IDLE.
//   - CLEAR: exactly 1 cycle; det_clr_o=1, driven from a flop so it is glitch-free. Go to SHIFT.
//   - SHIFT: det_vld_o=1, det_din_o=shift_reg MSB. On each edge:
//     - shift left with 0 fill; bit_cnt++.
//     - if match_i=1, count_o++ (saturating, no wrap).
//     - after the edge where bit_cnt reaches DATA_W-1, go to DONE.
//     SHIFT lasts exactly DATA_W cycles.
//   - DONE: 1 cycle; done_o=1; det_vld_o=0. Then IDLE (or SHIFT, see CONFIGURATION).
//   - Latency: start accepted at edge 0; det_clr_o high in cycle 1; bits in cycles 2..DATA_W+1;
//     done_o in cycle DATA_W+2. Throughput (non-continuous) is one frame per DATA_W+3 cycles.
//   - Ignored inputs: start_i in CLEAR/SHIFT is ignored (no queueing). data_i is only sampled
//     on acceptance. match_i outside SHIFT is ignored.
//   - Counter: only increments when det_vld_o=1. At 2**CNT_W-1 it holds.
//   - Reset mid-frame: rst_n low in any state -> immediate IDLE, outputs 0. The frame is
//     dropped and no done_o is produced.
//   - Frame bits are MSB first. Overlapping matches count, per detector semantics.
// CONFIGURATION
//   SEQ101_CTRL_CONT_EN defined:
//     - start_i=1 in DONE is accepted: capture data_i, count_o=0, go straight to SHIFT,
//       skipping CLEAR.
//     - Detector state carries across the frame boundary, so a 101 spanning two frames is
//       counted in the second frame.
//     - Back-to-back throughput is DATA_W+1 cycles per frame.
//   SEQ101_CTRL_CONT_EN undefined:
//     - start_i in DONE is ignored; every frame is preceded by CLEAR.
// TESTING
//   T1 reset: rst_n=0 -> busy_o=0, done_o=0, count_o=0, det_clr_o=0, det_vld_o=0.
//   T2 data_i=8'hAD, start pulse -> det_clr_o high 1 cycle; det_din_o streams 1,0,1,0,1,1,0,1;
//      done_o at cycle 10; count_o=3.
//   T3 data_i=8'hA5 -> count_o=2. data_i=8'h00 -> count_o=0. data_i=8'hFF -> count_o=0.
//   T4 CNT_W=1, data_i=8'hAD -> count_o=1 (saturated, no wrap to 0).
//   T5 rst_n pulsed low at the 4th SHIFT cycle -> IDLE, no done_o; a new 8'hA5 frame -> count_o=2.
//   T6 8'h01 then 8'h40, start_i held high through DONE:
//      - macro defined: frame 2 begins in the cycle after DONE, count_o=1.
//      - macro undefined: the DONE start is ignored; a re-issued start gives count_o=0.

Source files
------------

// File: rtl/seq101_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq101_stream_ctrl
//   Frame sequencer for a serial "101" Mealy detector.
//
//   Operation
//     1. Accepts a parallel byte on a start request.
//     2. Clears the detector for one cycle.
//     3. Streams the byte MSB-first into the detector, one bit per clock.
//     4. Counts the detector's match pulses, saturating at 2**CNT_W-1.
//     5. Reports the count with a one-cycle done pulse.
//
//   Optional feature (macro SEQ101_CTRL_CONT_EN)
//     - A start seen in DONE is accepted and the next frame goes straight
//       to SHIFT, without the CLEAR cycle.
//     - The detector state therefore carries across the frame boundary.
//
//   Ports
//     clk        in   1       system clock, rising edge
//     rst_n      in   1       asynchronous active-low reset
//     start_i    in   1       frame request (sampled in IDLE, and DONE when continuous)
//     data_i     in   DATA_W  frame payload, captured on acceptance
//     busy_o     out  1       high in CLEAR, SHIFT and DONE
//     done_o     out  1       one-cycle pulse, count_o valid
//     count_o    out  CNT_W   match count of the last frame
//     det_clr_o  out  1       registered detector clear
//     det_din_o  out  1       serial bit to the detector
//     det_vld_o  out  1       high while det_din_o carries a frame bit
//     match_i    in   1       detector Mealy output
// -----------------------------------------------------------------------------
module seq101_stream_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              det_clr_o,
   output logic              det_din_o,
   output logic              det_vld_o,
   input  logic              match_i
);

   localparam int               BCW      = $clog2(DATA_W);
   localparam logic [BCW-1:0]   LAST_BIT = BCW'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic                accept_s;
   logic [DATA_W-1:0]   shift_r;
   logic [BCW-1:0]      bit_cnt_r;
   logic [CNT_W-1:0]    count_r;
   logic                busy_r;
   logic                done_r;
   logic                clr_r;
   logic                vld_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and frame acceptance.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               accept_s = 1'b1;
               state_s  = ST_CLEAR;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            state_s = ST_SHIFT;
         end
         ST_SHIFT: begin
            // bit_cnt_r counts the bits already on det_din_o before this edge.
            if (bit_cnt_r == LAST_BIT) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
`ifdef SEQ101_CTRL_CONT_EN
            // Back-to-back frame: keep detector history, so no CLEAR cycle.
            if (start_i) begin
               accept_s = 1'b1;
               state_s  = ST_SHIFT;
            end else begin
               state_s  = ST_IDLE;
            end
`else
            state_s = ST_IDLE;
`endif
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from the next state and registered, so they
   // are glitch-free and line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         clr_r  <= 1'b0;
         vld_r  <= 1'b0;
      end else begin
         busy_r <= (state_s != ST_IDLE);
         done_r <= (state_s == ST_DONE);
         clr_r  <= (state_s == ST_CLEAR);
         vld_r  <= (state_s == ST_SHIFT);
      end
   end

   // Frame datapath: payload shifter, bit counter and saturating match counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r   <= {DATA_W{1'b0}};
         bit_cnt_r <= {BCW{1'b0}};
         count_r   <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         shift_r   <= data_i;
         bit_cnt_r <= {BCW{1'b0}};
         count_r   <= {CNT_W{1'b0}};
      end else if (state_r == ST_SHIFT) begin
         shift_r   <= {shift_r[DATA_W-2:0], 1'b0};
         bit_cnt_r <= bit_cnt_r + BCW'(1);
         if (match_i && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
         end else begin
            count_r <= count_r;
         end
      end else begin
         shift_r   <= shift_r;
         bit_cnt_r <= bit_cnt_r;
         count_r   <= count_r;
      end
   end

   assign busy_o    = busy_r;
   assign done_o    = done_r;
   assign count_o   = count_r;
   assign det_clr_o = clr_r;
   assign det_vld_o = vld_r;
   assign det_din_o = shift_r[DATA_W-1];

endmodule
